// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory for a CPU MEM stage with byte/half/word
// loads and stores, a fixed BUSY stall window and a registered load result.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     wd_q, wd_d, rdata_q, rdata_d;
    logic            wr_q, wr_d;
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic            req_ok, fire, unused_addr;
    logic [AW-1:0]   idx;
    logic [4:0]      sh;
    logic [15:0]     hw;
    logic [31:0]     word, wword, rword, lane_mask;
    assign unused_addr = ^ADDRESS[31:AW+2];
    assign req_ok    = MEM_READ ^ MEM_WRITE;
    assign idx       = addr_q[AW+1:2];
    assign word      = mem_q[idx];
    assign fire      = state_q == ACCESS && cnt_q == '0;
    assign BUSY      = !RST && ((state_q == IDLE && req_ok) || state_q == ACCESS);
    assign READ_DATA = rdata_q;
    // One shift serves both widths: odd FUNC3 selects halves, even selects bytes.
    always_comb begin
        sh        = f3_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
        hw        = 16'(word >> sh);
        lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        wword     = f3_q == 3'b010 ? wd_q :
                    (f3_q == 3'b000 || f3_q == 3'b001) ? (word & ~lane_mask) | ((wd_q << sh) & lane_mask) :
                    word;
        rword     = f3_q == 3'b000 ? {{24{hw[7]}}, hw[7:0]} :
                    f3_q == 3'b100 ? {24'b0, hw[7:0]} :
                    f3_q == 3'b001 ? {{16{hw[15]}}, hw} :
                    f3_q == 3'b101 ? {16'b0, hw} :
                    f3_q == 3'b010 ? word : '0;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_ok) begin
                state_d = ACCESS;
                cnt_d   = CW'(LATENCY - 2);
                addr_d  = ADDRESS[AW+1:0];
                f3_d    = FUNC3;
                wd_d    = WRITE_DATA;
                wr_d    = MEM_WRITE;
            end
            ACCESS: begin
                state_d = fire ? DONE : ACCESS;
                cnt_d   = fire ? cnt_q : cnt_q - CW'(1);
                rdata_d = (fire && !wr_q) ? rword : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            if (fire && wr_q) mem_q[idx] <= wword;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random accesses against a byte-lane memory model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, busy;
    logic [2:0]  func3;
    logic [31:0] address, write_data, read_data;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_rd;
    int          tests = 0;
    int          fails = 0;
    always #5 clk = ~clk;
    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK(clk), .RST(rst), .MEM_READ(mem_read), .MEM_WRITE(mem_write), .FUNC3(func3),
        .ADDRESS(address), .WRITE_DATA(write_data), .READ_DATA(read_data), .BUSY(busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    function automatic void model_reset();
        foreach (mem_m[i]) mem_m[i] = '0;
        exp_rd = '0;
    endfunction
    function automatic void model_apply(input logic r, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          i  = int'((a >> 2) % DEPTH);
        int          b  = int'(a[1:0]);
        int          h  = int'(a[1]);
        logic [31:0] w  = mem_m[i];
        logic [7:0]  bv = w[8*b +: 8];
        logic [15:0] hv = w[16*h +: 16];
        if (!r) begin
            case (f3)
                3'd0: mem_m[i][8*b +: 8] = wd[7:0];
                3'd1: mem_m[i][16*h +: 16] = wd[15:0];
                3'd2: mem_m[i] = wd;
                default: ;
            endcase
        end else begin
            case (f3)
                3'd0: exp_rd = {{24{bv[7]}}, bv};
                3'd1: exp_rd = {{16{hv[15]}}, hv};
                3'd2: exp_rd = w;
                3'd4: exp_rd = {24'b0, bv};
                3'd5: exp_rd = {16'b0, hv};
                default: exp_rd = '0;
            endcase
        end
    endfunction
    task automatic complete(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (busy && n < LAT + 4) begin
            n++;
            @(posedge clk);
            #1;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            func3      = 3'($urandom);
            address    = $urandom;
            write_data = $urandom;
            @(negedge clk);
        end
        check("busy_len", 32'(n), (r ^ w) ? LAT : 0);
        if (r ^ w) model_apply(r, f3, a, wd);
        check("read_data", read_data, exp_rd);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask
    task automatic acc(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        mem_read   = r;
        mem_write  = w;
        func3      = f3;
        address    = a;
        write_data = wd;
        complete(r, w, f3, a, wd);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = '0; address = '0; write_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        acc(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        check("lw_deadbeef", read_data, 32'hDEADBEEF);
        acc(1'b0, 1'b1, 3'd0, 32'h21, 32'h80);
        acc(1'b1, 1'b0, 3'd0, 32'h21, 32'h0);
        check("lb_sign", read_data, 32'hFFFFFF80);
        acc(1'b1, 1'b0, 3'd4, 32'h21, 32'h0);
        check("lbu_zero", read_data, 32'h00000080);
        acc(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        check("lw_byte_lane", read_data, 32'h00008000);
        acc(1'b0, 1'b1, 3'd2, 32'h30, 32'hAABBCCDD);
        acc(1'b0, 1'b1, 3'd1, 32'h32, 32'h1234);
        acc(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        check("lw_half_merge", read_data, 32'h1234CCDD);
        acc(1'b1, 1'b0, 3'd1, 32'h33, 32'h0);
        check("lh_upper", read_data, 32'h00001234);
        acc(1'b1, 1'b1, 3'd2, 32'h30, 32'hFFFFFFFF);
        check("both_req_hold", read_data, 32'h00001234);
        acc(1'b0, 1'b1, 3'd3, 32'h30, 32'h0);
        acc(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        check("f3_011_store", read_data, 32'h1234CCDD);
        mem_write = 1'b1; func3 = 3'd2; address = 32'h40; write_data = 32'h55;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        check("busy_in_rst", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rdata_after_rst", read_data, 32'd0);
        @(posedge clk);
        #1;
        acc(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
        check("lw_aborted", read_data, 32'd0);
        acc(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        check("mem_cleared", read_data, 32'd0);
        acc(1'b0, 1'b1, 3'd2, 32'h14, 32'hCAFEF00D);
        rst = 1'b1; mem_read = 1'b1; func3 = 3'd2; address = 32'h14;
        @(negedge clk);
        check("busy_rst_req", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        complete(1'b1, 1'b0, 3'd2, 32'h14, 32'h0);
        acc(1'b0, 1'b1, 3'd2, 32'h400, 32'h77);
        acc(1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
        check("wrap", read_data, 32'h00000077);
        mem_read = 1'b1; func3 = 3'd2; address = 32'h0;
        for (int i = 0; i < 2 * (LAT + 1); i++) begin
            @(negedge clk);
            check("b2b_busy", {31'b0, busy}, (i % (LAT + 1)) != LAT ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        mem_read = 1'b0;
        model_apply(1'b1, 3'd2, 32'h0, 32'h0);
        check("b2b_rdata", read_data, exp_rd);
        for (int k = 0; k < 300; k++) begin
            int          sel = int'($urandom_range(0, 9));
            logic        r   = sel < 4 || sel == 8;
            logic        w   = (sel >= 4 && sel < 8) || sel == 8;
            acc(r, w, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_F03F, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two, at least 4.
REQ-002 Parameter LATENCY, default 3, number of cycles BUSY is high per access; at least 2.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 MEM_READ  input  1  read request from the CPU MEM stage.
REQ-006 MEM_WRITE  input  1  write request from the CPU MEM stage.
REQ-007 FUNC3  input  3  access width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ADDRESS  input  32  byte address (ALU result).
REQ-009 WRITE_DATA  input  32  store data; byte/half taken from the low bits.
REQ-010 READ_DATA  output  32  registered load result, extended per FUNC3.
REQ-011 BUSY  output  1  stall request to the pipeline; high while an access is unfinished.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-013 In IDLE, exactly one of MEM_READ/MEM_WRITE high SHALL be accepted: latch ADDRESS, FUNC3, WRITE_DATA and the direction; load the counter with LATENCY-2; go to ACCESS.
REQ-014 In IDLE, MEM_READ and MEM_WRITE both high SHALL be ignored: no access, BUSY low, stay IDLE.
REQ-015 In ACCESS, counter 0 SHALL perform the access at that edge and go to DONE; otherwise the counter decrements.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE; requests are not sampled in DONE.
REQ-017 BUSY SHALL be combinational: high when (IDLE and a valid single request) or ACCESS; low in DONE and whenever RST is high.
REQ-018 BUSY SHALL be high for exactly LATENCY consecutive cycles per accepted access, starting in the request cycle.
REQ-019 Word index SHALL be latched ADDRESS[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so accesses wrap modulo the depth.
REQ-020 Store FUNC3 000 SHALL write the byte lane selected by ADDRESS[1:0].
REQ-021 Store FUNC3 001 SHALL write the half selected by ADDRESS[1]; ADDRESS[0] is ignored.
REQ-022 Store FUNC3 010 SHALL write the full word; ADDRESS[1:0] is ignored.
REQ-023 A store with any other FUNC3 SHALL leave memory unchanged.
REQ-024 Load 000/001 SHALL sign-extend and 100/101 SHALL zero-extend the selected lane; 010 SHALL return the word.
REQ-025 A load with any other FUNC3 SHALL return 0.
REQ-026 READ_DATA SHALL update only on the edge entering DONE for a load; it holds through stores and idle cycles.
REQ-027 READ_DATA SHALL be valid in the DONE cycle, when BUSY is first low.
REQ-028 Memory SHALL be read and written only by the latched request; input changes after acceptance have no effect.

Reset
REQ-029 With RST high at an edge: state IDLE, counter 0, READ_DATA 0x00000000, all memory words 0.
REQ-030 With RST high at an edge: latched request cleared; an in-flight write is aborted and the target word is unchanged (zero after clear).
REQ-031 RST SHALL take priority over every other condition in the same cycle.
REQ-032 After RST falls, a request held high SHALL be accepted in the first IDLE cycle.

Verification
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10 -> each BUSY high 3 cycles; LW READ_DATA=0xDEADBEEF in DONE.
REQ-034 SB 0x80 @0x21, then LB @0x21 and LBU @0x21 -> 0xFFFFFF80 and 0x00000080; LW @0x20 -> 0x00008000.
REQ-035 SH 0x1234 @0x32 over word 0xAABBCCDD @0x30 -> LW @0x30 = 0x1234CCDD; LH @0x33 = 0x00001234.
REQ-036 MEM_READ and MEM_WRITE both high -> BUSY stays 0, memory and READ_DATA unchanged; FUNC3 011 store -> word unchanged.
REQ-037 SW 0x55 @0x40 with RST pulsed in the 2nd BUSY cycle -> BUSY 0 during RST; then LW @0x40 = 0, READ_DATA 0 after reset.
REQ-038 With DEPTH_WORDS=256, SW 0x77 @0x400, then LW @0x0 -> 0x00000077 (wrap); back-to-back requests -> exactly one DONE cycle between them.
